// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-register I2C master.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR_W,
        ACK_A,
        IDX,
        ACK_I,
        WDATA,
        ACK_D,
        RSTART,
        ADDR_R,
        ACK_R,
        RDATA,
        MNACK,
        STOP
    } i2c_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_qtr_timer.sv
// SCL quarter-period timer: counts 0..QTR_DIV-1 and advances a 2-bit quarter index.
// hold freezes the counter at 0 so a slave can stretch SCL.
module i2c_qtr_timer #(
    parameter int unsigned QTR_DIV = 250,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       start_rst,
    input  logic       en,
    input  logic       hold,
    input  logic       last,
    output logic       qtr_tick,
    output logic [1:0] qtr
);

    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall    = hold && (cnt == '0);
    assign qtr_tick = en && !stall && (cnt == CNT_W'(QTR_DIV - 1));

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            cnt <= '0;
            qtr <= '0;
        end else if (!en) begin
            cnt <= '0;
            qtr <= '0;
        end else if (qtr_tick) begin
            cnt <= '0;
            qtr <= last ? 2'd0 : qtr + 2'd1;
        end else if (!stall) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-register I2C master: write (S, addr+W, idx, data, P) or read (S, addr+W, idx, Sr, addr+R, byte, NACK, P).
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL; otherwise scl_i is ignored.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int unsigned QTR_DIV = 250,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       start_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_idx,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    i2c_state_t state, state_nxt;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [7:0] idx_q, wdata_q, tx_sr, rx_sr;
    logic [2:0] bit_cnt;
    logic       ack_bit;
    logic [1:0] sda_sync;
    logic [1:0] qtr;
    logic       qtr_tick, last_qtr, hold, bit_end, sample;
    logic       scl_rel, sda_rel;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign bit_end   = qtr_tick && last_qtr;
    assign sample    = qtr_tick && (qtr == 2'd1);

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) sda_sync <= 2'b11;
        else           sda_sync <= {sda_sync[0], sda_i};
    end

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) scl_sync <= 2'b11;
        else           scl_sync <= {scl_sync[0], scl_i};
    end
    // SCL released but still read low: a slave is stretching, so freeze the quarter.
    assign hold = busy && scl_rel && !scl_sync[1];
`else
    logic scl_unused;
    assign scl_unused = scl_i;
    assign hold       = 1'b0;
`endif

    i2c_qtr_timer #(
        .QTR_DIV (QTR_DIV),
        .CNT_W   (CNT_W)
    ) u_qtr_timer (
        .clk       (clk),
        .start_rst (start_rst),
        .en        (busy),
        .hold      (hold),
        .last      (last_qtr),
        .qtr_tick  (qtr_tick),
        .qtr       (qtr)
    );

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl_rel   = 1'b1;
        sda_rel   = 1'b1;
        last_qtr  = (qtr == 2'd3);
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = START;
            end
            START: begin
                last_qtr = (qtr == 2'd1);
                scl_rel  = (qtr == 2'd0);
                sda_rel  = 1'b0;
                if (bit_end) state_nxt = ADDR_W;
            end
            ADDR_W, IDX, WDATA, ADDR_R, RDATA: begin
                scl_rel = (qtr == 2'd1) || (qtr == 2'd2);
                sda_rel = (state == RDATA) ? 1'b1 : tx_sr[7];
                if (bit_end && bit_cnt == 3'd7) begin
                    case (state)
                        ADDR_W:  state_nxt = ACK_A;
                        IDX:     state_nxt = ACK_I;
                        WDATA:   state_nxt = ACK_D;
                        ADDR_R:  state_nxt = ACK_R;
                        default: state_nxt = MNACK;
                    endcase
                end
            end
            ACK_A, ACK_I, ACK_D, ACK_R, MNACK: begin
                scl_rel = (qtr == 2'd1) || (qtr == 2'd2);
                if (bit_end) begin
                    if (state != MNACK && ack_bit == NACK_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        case (state)
                            ACK_A:   state_nxt = IDX;
                            ACK_I:   state_nxt = (rw_q == RW_READ) ? RSTART : WDATA;
                            ACK_R:   state_nxt = RDATA;
                            default: state_nxt = STOP;
                        endcase
                    end
                end
            end
            RSTART: begin
                scl_rel = (qtr == 2'd1) || (qtr == 2'd2);
                sda_rel = (qtr == 2'd0) || (qtr == 2'd1);
                if (bit_end) state_nxt = ADDR_R;
            end
            STOP: begin
                last_qtr = (qtr == 2'd2);
                scl_rel  = (qtr != 2'd0);
                sda_rel  = (qtr == 2'd2);
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            rw_q    <= RW_WRITE;
            addr_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            ack_bit <= ACK_BIT;
            ack_err <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            done   <= 1'b0;
            scl_oe <= ~scl_rel;
            sda_oe <= ~sda_rel;
            if (cmd_valid && cmd_ready) begin
                rw_q    <= cmd_rw;
                addr_q  <= cmd_addr;
                idx_q   <= cmd_idx;
                wdata_q <= cmd_wdata;
                bit_cnt <= '0;
                ack_err <= 1'b0;
            end
            if (sample) begin
                ack_bit <= sda_sync[1];
                if (state == RDATA) rx_sr <= {rx_sr[6:0], sda_sync[1]};
            end
            if (bit_end) begin
                case (state)
                    ADDR_W, IDX, WDATA, ADDR_R: begin
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RDATA: bit_cnt <= bit_cnt + 3'd1;
                    ACK_A, ACK_I, ACK_D, ACK_R: begin
                        if (ack_bit == NACK_BIT) ack_err <= 1'b1;
                    end
                    STOP: begin
                        done <= 1'b1;
                        if (rw_q == RW_READ && !ack_err) rdata <= rx_sr;
                    end
                    default: ;
                endcase
            end
            // Load the outgoing byte on entry; overrides the shift above.
            if (state_nxt != state) begin
                case (state_nxt)
                    ADDR_W:  tx_sr <= {addr_q, RW_WRITE};
                    IDX:     tx_sr <= idx_q;
                    WDATA:   tx_sr <= wdata_q;
                    ADDR_R:  tx_sr <= {addr_q, RW_READ};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench for i2c_master_controller with a behavioural register slave at address 0x55.
module tb_i2c_master_controller;

    localparam int unsigned QTR = 4;
    localparam int S_EV     = 256;
    localparam int P_EV     = 257;
    localparam int MNACK_EV = 258;
    localparam int MACK_EV  = 259;
    localparam int SL_IDLE = 0, SL_RX = 1, SL_ACK = 2, SL_TX = 3, SL_MACK = 4;
    localparam logic [6:0] SLV_ADDR = 7'h55;

    logic       clk = 1'b0;
    logic       start_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_idx = '0;
    logic [7:0] cmd_wdata = '0;
    logic       busy, done, ack_err;
    logic [7:0] rdata;
    logic       scl_oe, sda_oe;
    logic       scl_line, sda_line;
    logic       sl_scl_low = 1'b0;
    logic       sl_sda_low = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_accept = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    assign scl_line = ~scl_oe & ~sl_scl_low;
    assign sda_line = ~sda_oe & ~sl_sda_low;

    i2c_master_controller #(
        .QTR_DIV (QTR),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .start_rst (start_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_idx   (cmd_idx),
        .cmd_wdata (cmd_wdata),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .rdata     (rdata),
        .scl_i     (scl_line),
        .sda_i     (sda_line),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!start_rst && cmd_valid && cmd_ready) n_accept = n_accept + 1;
    end

    // Behavioural slave, sampled on the falling clk edge.
    int         bus_log[$];
    logic [7:0] sl_regs [256];
    logic [7:0] sl_sr = '0;
    logic [7:0] sl_ptr = '0;
    int         sl_st = SL_IDLE;
    int         sl_bit = 0;
    int         sl_byte = 0;
    int         stretch_cnt = 0;
    logic       sl_rd = 1'b0;
    logic       sl_ack = 1'b0;
    logic       stretch_on_idx = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    always @(negedge clk) begin
        if (stretch_cnt > 0) begin
            stretch_cnt = stretch_cnt - 1;
            if (stretch_cnt == 0) sl_scl_low = 1'b0;
        end
        if (prev_scl && scl_line && prev_sda && !sda_line) begin
            bus_log.push_back(S_EV);
            sl_st = SL_RX; sl_bit = 0; sl_byte = 0; sl_sda_low = 1'b0;
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
            bus_log.push_back(P_EV);
            sl_st = SL_IDLE; sl_sda_low = 1'b0;
        end else if (!prev_scl && scl_line) begin
            if (sl_st == SL_RX) begin
                sl_sr  = {sl_sr[6:0], sda_line};
                sl_bit = sl_bit + 1;
            end else if (sl_st == SL_MACK) begin
                bus_log.push_back(sda_line ? MNACK_EV : MACK_EV);
            end
        end else if (prev_scl && !scl_line) begin
            case (sl_st)
                SL_RX: if (sl_bit == 8) begin
                    bus_log.push_back(int'(sl_sr));
                    sl_ack = 1'b0;
                    if (sl_byte == 0) begin
                        sl_ack = (sl_sr[7:1] == SLV_ADDR);
                        sl_rd  = sl_sr[0];
                    end else if (sl_byte == 1) begin
                        sl_ptr = sl_sr; sl_ack = 1'b1;
                        if (stretch_on_idx) begin
                            sl_scl_low  = 1'b1;
                            stretch_cnt = 1000;
                        end
                    end else if (sl_byte == 2) begin
                        sl_regs[sl_ptr] = sl_sr; sl_ack = 1'b1;
                    end
                    sl_byte    = sl_byte + 1;
                    sl_st      = sl_ack ? SL_ACK : SL_IDLE;
                    sl_sda_low = sl_ack;
                end
                SL_ACK: begin
                    sl_sda_low = 1'b0;
                    sl_bit     = 0;
                    if (sl_rd) begin
                        sl_st      = SL_TX;
                        sl_sr      = sl_regs[sl_ptr];
                        sl_sda_low = ~sl_sr[7];
                    end else begin
                        sl_st = SL_RX;
                    end
                end
                SL_TX: begin
                    sl_bit = sl_bit + 1;
                    if (sl_bit == 8) begin
                        sl_sda_low = 1'b0;
                        sl_st      = SL_MACK;
                    end else begin
                        sl_sda_low = ~sl_sr[7 - sl_bit];
                    end
                end
                SL_MACK: sl_st = SL_IDLE;
                default: ;
            endcase
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] i, input logic [7:0] d);
        @(negedge clk);
        cmd_rw = rw; cmd_addr = a; cmd_idx = i; cmd_wdata = d; cmd_valid = 1'b1;
        for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic err, output logic [7:0] rd);
        logic seen;
        seen = 1'b0; err = 1'b0; rd = '0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; err = ack_err; rd = rdata;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_len"}, 32'(bus_log.size()), 32'(exp.size()));
        foreach (exp[k])
            if (k < bus_log.size()) check($sformatf("%s_ev%0d", tag, k), bus_log[k], exp[k]);
    endtask

    initial begin
        logic       err;
        logic [7:0] rd;
        logic       ok;
        int         exp_q[$];
        int         t0;

        for (int r = 0; r < 256; r++) sl_regs[r] = '0;
        repeat (3) @(negedge clk);
        start_rst = 1'b0;
        @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ready", cmd_ready, 1);

        // 1: register write
        bus_log.delete();
        issue(1'b0, 7'h55, 8'h03, 8'h57);
        check("wr_busy", busy, 1);
        wait_done("wr", err, rd);
        check("wr_ack_err", err, 0);
        check("wr_reg03", sl_regs[8'h03], 8'h57);
        check("wr_rdata_kept", rd, 8'h00);
        exp_q = {S_EV, 'hAA, 'h03, 'h57, P_EV};
        check_log("wr_log", exp_q);

        // 2: register read back
        repeat (5) @(negedge clk);
        bus_log.delete();
        issue(1'b1, 7'h55, 8'h03, 8'h00);
        wait_done("rd", err, rd);
        check("rd_ack_err", err, 0);
        check("rd_rdata", rd, 8'h57);
        exp_q = {S_EV, 'hAA, 'h03, S_EV, 'hAB, MNACK_EV, P_EV};
        check_log("rd_log", exp_q);

        // 3: absent slave
        repeat (5) @(negedge clk);
        bus_log.delete();
        issue(1'b0, 7'h22, 8'h03, 8'h99);
        wait_done("nack", err, rd);
        check("nack_ack_err", err, 1);
        check("nack_rdata_kept", rd, 8'h57);
        check("nack_reg03", sl_regs[8'h03], 8'h57);
        exp_q = {S_EV, 'h44, P_EV};
        check_log("nack_log", exp_q);

        // 4: reset in the middle of the index byte
        repeat (5) @(negedge clk);
        issue(1'b0, 7'h55, 8'h09, 8'hFF);
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            if (sl_st == SL_RX && sl_byte == 1 && sl_bit == 3) ok = 1'b1;
        end
        check("rst_mid_reach", 32'(ok), 1);
        check("rst_mid_busy_before", busy, 1);
        #2 start_rst = 1'b1;
        #1;
        check("rst_mid_scl_oe", scl_oe, 0);
        check("rst_mid_sda_oe", sda_oe, 0);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(negedge clk);
        start_rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", cmd_ready, 1);
        bus_log.delete();
        issue(1'b0, 7'h55, 8'h05, 8'h3C);
        wait_done("rst_new", err, rd);
        check("rst_new_ack_err", err, 0);
        check("rst_new_reg05", sl_regs[8'h05], 8'h3C);
        check("rst_aborted_reg09", sl_regs[8'h09], 8'h00);

        // 5: cmd_valid held through a busy transaction
        repeat (5) @(negedge clk);
        n_accept = 0;
        cmd_rw = 1'b0; cmd_addr = 7'h55; cmd_idx = 8'h07; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        wait_done("hold1", err, rd);
        check("hold1_accepts", n_accept, 1);
        cmd_idx = 8'h08; cmd_wdata = 8'h22;
        @(negedge clk);
        check("hold2_busy", busy, 1);
        check("hold2_accepts", n_accept, 2);
        cmd_valid = 1'b0;
        wait_done("hold2", err, rd);
        check("hold_final_accepts", n_accept, 2);
        check("hold_reg07", sl_regs[8'h07], 8'h11);
        check("hold_reg08", sl_regs[8'h08], 8'h22);

`ifdef I2C_CLK_STRETCH_EN
        // 6: slave stretches SCL in the index ACK slot
        repeat (5) @(negedge clk);
        bus_log.delete();
        stretch_on_idx = 1'b1;
        t0 = cyc;
        issue(1'b0, 7'h55, 8'h0A, 8'hC3);
        wait_done("str", err, rd);
        stretch_on_idx = 1'b0;
        check("str_waited", 32'((cyc - t0) > 1000), 1);
        check("str_ack_err", err, 0);
        check("str_reg0a", sl_regs[8'h0A], 8'hC3);
        exp_q = {S_EV, 'hAA, 'h0A, 'hC3, P_EV};
        check_log("str_log", exp_q);
`else
        t0 = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
